// File: rtl/remote_comm_pkg.sv
// ---------------------------------------------------------------------------
// remote_comm_pkg
// Shared types and constants for the knight-robot host command link.
//   tx_state_e : two-byte command sequencer states (IDLE, HIGH, LOW)
//   rx_state_e : UART receiver states
//   DATA_BITS, START, STOP : 8N1 frame constants
// ---------------------------------------------------------------------------
package remote_comm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam int   DATA_BITS = 8;
  localparam logic START     = 1'b0;
  localparam logic STOP      = 1'b1;

endpackage

// File: rtl/remote_comm_uart_xcvr.sv
// ---------------------------------------------------------------------------
// uart_xcvr
// Full-duplex 8N1 UART transmitter and receiver sharing one baud divisor.
// Parameters:
//   BAUD_DIV : clock cycles per bit (minimum 4)
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   RX            : asynchronous serial input, idle high
//   TX            : registered serial output, idle high
//   tx_data, trmt : byte to send and load strobe
//   tx_done       : high during the final cycle of the stop bit
//   rx_data, rdy  : last good received byte and its one-cycle strobe
// ---------------------------------------------------------------------------
module uart_xcvr
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic       TX,
  input  logic [7:0] tx_data,
  input  logic       trmt,
  output logic       tx_done,
  output logic [7:0] rx_data,
  output logic       rdy
);

  localparam int CW   = $clog2(BAUD_DIV);
  localparam int HALF = BAUD_DIV / 2;

  logic [CW-1:0] tx_baud_q;
  logic [3:0]    tx_bit_q;
  logic [8:0]    tx_shift_q;
  logic          tx_q;
  logic          tx_busy_q;

  logic          rx_s1_q, rx_s2_q, rx_s3_q;
  logic          rx_fall;
  rx_state_e     rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic [7:0]    rx_data_q;
  logic          rdy_q;

  // tx_done marks the last cycle of the stop bit so a new byte loaded on the
  // same edge starts its start bit with no idle gap.
  assign tx_done = tx_busy_q && (tx_baud_q == CW'(BAUD_DIV - 1)) && (tx_bit_q == 4'd9);
  assign TX      = tx_q;
  assign rx_data = rx_data_q;
  assign rdy     = rdy_q;

  // Transmitter: the start bit is driven at load time, then the shift register
  // holds the data bits LSB first followed by the stop bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q       <= STOP;
      tx_busy_q  <= 1'b0;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
    end else if (trmt && (!tx_busy_q || tx_done)) begin
      tx_q       <= START;
      tx_shift_q <= {STOP, tx_data};
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_busy_q  <= 1'b1;
    end else if (tx_busy_q) begin
      if (tx_baud_q == CW'(BAUD_DIV - 1)) begin
        tx_baud_q <= '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_q <= 1'b0;
          tx_q      <= STOP;
        end else begin
          tx_q       <= tx_shift_q[0];
          tx_shift_q <= {STOP, tx_shift_q[8:1]};
          tx_bit_q   <= tx_bit_q + 1'b1;
        end
      end else begin
        tx_baud_q <= tx_baud_q + 1'b1;
      end
    end
  end

  // Two flops bring RX into the clock domain; the third only feeds the edge
  // detector so it never looks at a possibly metastable value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= RX;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  assign rx_fall = rx_s3_q & ~rx_s2_q;

  // Receiver: re-check the start bit at mid-bit to reject glitches, then
  // sample each following bit one full bit time later (mid-bit).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rdy_q      <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_q == CW'(HALF - 1)) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            if (rx_s2_q == STOP) rx_state_q <= RX_IDLE;
            else                 rx_state_q <= RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == CW'(BAUD_DIV - 1)) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'(DATA_BITS - 1)) rx_state_q <= RX_STOP;
            else                               rx_bit_q   <= rx_bit_q + 1'b1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == CW'(BAUD_DIV - 1)) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_IDLE;
            if (rx_s2_q == STOP) begin
              rx_data_q <= rx_shift_q;
              rdy_q     <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/remote_comm.sv
// ---------------------------------------------------------------------------
// remote_comm
// Host-side command link: sends a 16-bit command as two 8N1 bytes (high byte
// first, back-to-back) and reports received single-byte responses.
// Parameters:
//   BAUD_DIV    : clock cycles per UART bit (minimum 4)
//   TIMEOUT_CYC : response timeout in cycles (only with RESP_TIMEOUT_EN)
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   cmd, send_cmd     : command word and its send request
//   cmd_sent          : level, set when both bytes have left the wire
//   resp, resp_rdy    : last received byte and its one-cycle strobe
//   TX, RX            : UART serial pins
//   resp_tmo          : response timeout flag (only with RESP_TIMEOUT_EN)
// Build option: define RESP_TIMEOUT_EN to add the response timeout.
// ---------------------------------------------------------------------------
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = 2604
`ifdef RESP_TIMEOUT_EN
  ,parameter int TIMEOUT_CYC = 50_000_000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        send_cmd,
  output logic        cmd_sent,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  output logic        TX,
  input  logic        RX
`ifdef RESP_TIMEOUT_EN
  ,output logic       resp_tmo
`endif
);

  tx_state_e  state_q;
  logic [7:0] low_q;
  logic       cmd_sent_q;
  logic [7:0] resp_q;
  logic       resp_rdy_q;

  logic       trmt_d;
  logic [7:0] tx_data_d;
  logic       tx_done;
  logic [7:0] rx_data;
  logic       rdy;
  logic       accept;
  logic       sent_rise;

  assign accept    = (state_q == IDLE) && send_cmd;
  assign sent_rise = (state_q == LOW) && tx_done;

  // The low byte is handed over combinationally on tx_done so the second
  // frame's start bit follows the first stop bit with no idle cycle.
  assign trmt_d    = accept || ((state_q == HIGH) && tx_done);
  assign tx_data_d = (state_q == IDLE) ? cmd[15:8] : low_q;

  uart_xcvr #(
    .BAUD_DIV(BAUD_DIV)
  ) u_xcvr (
    .clk    (clk),
    .rst    (rst),
    .RX     (RX),
    .TX     (TX),
    .tx_data(tx_data_d),
    .trmt   (trmt_d),
    .tx_done(tx_done),
    .rx_data(rx_data),
    .rdy    (rdy)
  );

  // Two-byte sequencer; the low byte is captured at acceptance so later
  // changes on cmd cannot corrupt the frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      low_q      <= '0;
      cmd_sent_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (send_cmd) begin
            low_q      <= cmd[7:0];
            cmd_sent_q <= 1'b0;
            state_q    <= HIGH;
          end
        end
        HIGH: begin
          if (tx_done) state_q <= LOW;
        end
        LOW: begin
          if (tx_done) begin
            cmd_sent_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Response output registers: resp holds until the next good byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_q     <= '0;
      resp_rdy_q <= 1'b0;
    end else begin
      resp_rdy_q <= rdy;
      if (rdy) resp_q <= rx_data;
    end
  end

  assign cmd_sent = cmd_sent_q;
  assign resp     = resp_q;
  assign resp_rdy = resp_rdy_q;

`ifdef RESP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tmo_cnt_q;
  logic          tmo_run_q;
  logic          resp_tmo_q;

  // Timeout counter runs from the cmd_sent rise until a response arrives;
  // resp_tmo is set TIMEOUT_CYC cycles after cmd_sent if nothing came back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q  <= '0;
      tmo_run_q  <= 1'b0;
      resp_tmo_q <= 1'b0;
    end else if (accept) begin
      tmo_cnt_q  <= '0;
      tmo_run_q  <= 1'b0;
      resp_tmo_q <= 1'b0;
    end else if (sent_rise) begin
      tmo_cnt_q <= '0;
      tmo_run_q <= 1'b1;
    end else if (tmo_run_q) begin
      if (resp_rdy_q) begin
        tmo_run_q <= 1'b0;
      end else if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
        resp_tmo_q <= 1'b1;
        tmo_run_q  <= 1'b0;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
    end
  end

  assign resp_tmo = resp_tmo_q;
`endif

endmodule

// File: tb/tb_remote_comm.sv
// ---------------------------------------------------------------------------
// tb_remote_comm
// Self-checking bench for remote_comm with BAUD_DIV=16. A frame-level model
// predicts TX and cmd_sent from the accepted command; a byte scoreboard
// predicts every resp_rdy. Define RESP_TIMEOUT_EN to also exercise resp_tmo.
// ---------------------------------------------------------------------------
module tb_remote_comm;

  localparam int B     = 16;
  localparam int FRAME = 10 * B;
`ifdef RESP_TIMEOUT_EN
  localparam int TMO   = 1000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd;
  logic        send_cmd;
  logic        cmd_sent;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        TX;
  logic        RX;
  logic        rxDrv;
  logic        loopEn;
`ifdef RESP_TIMEOUT_EN
  logic        resp_tmo;
`endif

  int checks = 0;
  int passes = 0;

  // Model state
  int          cyc = 0;
  int          acceptCyc = -100000;
  bit          mBusy = 1'b0;
  logic [15:0] mCmd = '0;
  logic        expCmdSent = 1'b0;
  logic [7:0]  expQ[$];

  // Compare-process bookkeeping
  logic        prevRdy = 1'b0;
  logic        prevSent = 1'b0;
  logic [7:0]  lastResp = '0;
  int          rdyCount = 0;
  int          sentRises = 0;
  logic [7:0]  rxLog[$];
  logic [7:0]  eb;

  always #5 clk = ~clk;

  assign RX = loopEn ? TX : rxDrv;

  remote_comm #(
    .BAUD_DIV(B)
`ifdef RESP_TIMEOUT_EN
    ,.TIMEOUT_CYC(TMO)
`endif
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cmd     (cmd),
    .send_cmd(send_cmd),
    .cmd_sent(cmd_sent),
    .resp    (resp),
    .resp_rdy(resp_rdy),
    .TX      (TX),
    .RX      (RX)
`ifdef RESP_TIMEOUT_EN
    ,.resp_tmo(resp_tmo)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h (t=%0t)", name, actual, expected, $time);
  endtask

  // Requests a send; returns just after the edge that samples send_cmd, and
  // scrambles cmd so any late use of it would show on the wire.
  task automatic applyStimulus(input logic [15:0] c);
    @(negedge clk);
    cmd      = c;
    send_cmd = 1'b1;
    @(posedge clk);
    #1;
    send_cmd = 1'b0;
    cmd      = ~c;
  endtask

  // Drives one 8N1-style frame on RX with a chosen stop bit.
  task automatic sendUartByte(input logic [7:0] d, input logic stopBit);
    logic [9:0] bits;
    bits = {stopBit, d, 1'b0};
    if (stopBit) expQ.push_back(d);
    for (int i = 0; i < 10; i++) begin
      rxDrv = bits[i];
      repeat (B) @(negedge clk);
    end
    rxDrv = 1'b1;
  endtask

  task automatic waitCmdSent();
    for (int i = 0; i < 2 * FRAME + 50 && !cmd_sent; i++) @(negedge clk);
    checkOutput("cmd_sent wait", 32'(cmd_sent), 32'd1);
  endtask

  // Expected TX: after the accepting edge, two 10-bit frames of B cycles
  // per bit (start 0, data LSB first, stop 1); idle high otherwise.
  function automatic logic expTx();
    int j;
    int f;
    int b;
    logic [7:0] by;
    j = cyc - acceptCyc;
    if (j < 0 || j >= 2 * FRAME) return 1'b1;
    f  = j / FRAME;
    b  = (j % FRAME) / B;
    by = (f == 0) ? mCmd[15:8] : mCmd[7:0];
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return by[b-1];
  endfunction

  // Model: accepts a command when not busy, finishes 2*FRAME edges later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc        = 0;
      mBusy      = 1'b0;
      acceptCyc  = -100000;
      expCmdSent = 1'b0;
    end else begin
      cyc++;
      if (send_cmd && !mBusy) begin
        mBusy      = 1'b1;
        acceptCyc  = cyc;
        mCmd       = cmd;
        expCmdSent = 1'b0;
        if (loopEn) begin
          expQ.push_back(cmd[15:8]);
          expQ.push_back(cmd[7:0]);
        end
      end else if (mBusy && cyc == acceptCyc + 2 * FRAME) begin
        mBusy      = 1'b0;
        expCmdSent = 1'b1;
      end
    end
  end

  // Compare process: checks outputs on every cycle out of reset.
  always @(negedge clk) begin
    if (rst) begin
      prevRdy   = 1'b0;
      prevSent  = 1'b0;
      lastResp  = '0;
      rdyCount  = 0;
      sentRises = 0;
      rxLog.delete();
    end else if (cyc > 0) begin
      checkOutput("TX", 32'(TX), 32'(expTx()));
      checkOutput("cmd_sent", 32'(cmd_sent), 32'(expCmdSent));
      checkOutput("resp_rdy width", 32'(resp_rdy & prevRdy), 32'd0);
      if (resp_rdy) begin
        rdyCount++;
        rxLog.push_back(resp);
        if (expQ.size() == 0) begin
          checkOutput("resp_rdy unexpected", 32'(resp_rdy), 32'd0);
        end else begin
          eb = expQ.pop_front();
          checkOutput("resp", 32'(resp), 32'(eb));
          lastResp = eb;
        end
      end else begin
        checkOutput("resp hold", 32'(resp), 32'(lastResp));
      end
      if (cmd_sent && !prevSent) sentRises++;
      prevRdy  = resp_rdy;
      prevSent = cmd_sent;
    end
  end

  initial begin
    rst      = 1'b1;
    send_cmd = 1'b0;
    cmd      = '0;
    rxDrv    = 1'b1;
    loopEn   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset TX", 32'(TX), 32'd1);
    checkOutput("reset cmd_sent", 32'(cmd_sent), 32'd0);
    checkOutput("reset resp_rdy", 32'(resp_rdy), 32'd0);
    checkOutput("reset resp", 32'(resp), 32'h00);
`ifdef RESP_TIMEOUT_EN
    checkOutput("reset resp_tmo", 32'(resp_tmo), 32'd0);
`endif
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Loopback command 0x5AC3 with an ignored send_cmd mid-frame.
    $display("[TB] loopback command 0x5AC3");
    applyStimulus(16'h5AC3);
    for (int k = 0; k <= 322; k++) begin
      @(negedge clk);
      if (k == 0)   checkOutput("first start bit", 32'(TX), 32'd0);
      if (k == 16)  checkOutput("0x5A bit0", 32'(TX), 32'd0);
      if (k == 32)  checkOutput("0x5A bit1", 32'(TX), 32'd1);
      if (k == 160) checkOutput("second start bit", 32'(TX), 32'd0);
      if (k == 176) checkOutput("0xC3 bit0", 32'(TX), 32'd1);
      if (k == 50) begin
        cmd      = 16'hFFFF;
        send_cmd = 1'b1;
      end
      if (k == 51)  send_cmd = 1'b0;
      if (k == 319) checkOutput("cmd_sent at 319", 32'(cmd_sent), 32'd0);
      if (k == 320) checkOutput("cmd_sent at 320", 32'(cmd_sent), 32'd1);
    end
    repeat (20) @(negedge clk);
    checkOutput("loopback rdy count", 32'(rdyCount), 32'd2);
    checkOutput("cmd_sent rises", 32'(sentRises), 32'd1);
    if (rxLog.size() >= 2) begin
      checkOutput("loopback byte0", 32'(rxLog[0]), 32'h5A);
      checkOutput("loopback byte1", 32'(rxLog[1]), 32'hC3);
    end else begin
      checkOutput("loopback log size", 32'(rxLog.size()), 32'd2);
    end

    // External driver: framing error, then a good byte.
    $display("[TB] external RX bytes");
    loopEn = 1'b0;
    repeat (10) @(negedge clk);
    sendUartByte(8'hA5, 1'b0);
    repeat (3 * B) @(negedge clk);
    checkOutput("framing error dropped", 32'(rdyCount), 32'd2);
    checkOutput("resp after framing error", 32'(resp), 32'hC3);
    sendUartByte(8'hA5, 1'b1);
    repeat (3 * B) @(negedge clk);
    checkOutput("good byte rdy count", 32'(rdyCount), 32'd3);
    checkOutput("good byte resp", 32'(resp), 32'hA5);

    // Short low glitch while idle.
    $display("[TB] RX glitch");
    rxDrv = 1'b0;
    repeat (3) @(negedge clk);
    rxDrv = 1'b1;
    repeat (5 * B) @(negedge clk);
    checkOutput("glitch ignored", 32'(rdyCount), 32'd3);

`ifdef RESP_TIMEOUT_EN
    // No response: resp_tmo rises exactly TMO cycles after cmd_sent.
    $display("[TB] response timeout");
    applyStimulus(16'h1234);
    @(negedge clk);
    checkOutput("resp_tmo cleared on send", 32'(resp_tmo), 32'd0);
    waitCmdSent();
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      if (k == 999)  checkOutput("resp_tmo at 999", 32'(resp_tmo), 32'd0);
      if (k == 1000) checkOutput("resp_tmo at 1000", 32'(resp_tmo), 32'd1);
    end

    // Response around cycle 500 stops the counter.
    applyStimulus(16'h0F0F);
    @(negedge clk);
    checkOutput("resp_tmo cleared by send", 32'(resp_tmo), 32'd0);
    waitCmdSent();
    repeat (340) @(negedge clk);
    sendUartByte(8'h3C, 1'b1);
    repeat (600) @(negedge clk);
    checkOutput("resp_tmo after response", 32'(resp_tmo), 32'd0);
    checkOutput("timeout run resp", 32'(resp), 32'h3C);
`endif

    checkOutput("expected bytes drained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
